vga_gain_sequencer: RTL and testbench
=====================================

Name: vga_gain_sequencer

Overview:
Sits directly downstream of the AGC gain binary search. Takes the 6-bit gain code and the search-done flag, and drives the 64-bit VGA control word. It never applies a gain jump in one cycle: it walks the applied gain toward the requested target in bounded steps, with a settle interval between steps, so the VGA chain does not see large transients. Once the search reports done and the applied gain has converged, it locks the gain.

Parameters:
INIT_GAIN, 32, applied/target gain after reset (0..63)
MAX_STEP, 8, largest change of applied gain per step (1..63)
SETTLE_CYCLES, 4, cycles spent in SETTLE after each step (1..15)

Ports:
clk  input  1  system clock
RESET  input  1  synchronous, active-high reset
gain_array  input  6  requested gain code from binary search
gain_valid  input  1  one-cycle strobe: gain_array holds a new request
done  input  1  level, high while binary search is finished
vga_control  output  64  registered thermometer control word to the VGAs
current_gain  output  6  registered applied gain code
busy  output  1  high while state is STEP or SETTLE
locked  output  1  high while state is LOCKED

Behaviour:
- Reset (sampled on posedge clk while RESET=1; also applies mid-operation):
  - state=IDLE, current_gain=target=INIT_GAIN, settle counter=0
  - vga_control=thermo(INIT_GAIN), busy=0, locked=0
- thermo(g): bits [g-1:0]=1, all other bits 0; g=0 gives all zeros.
- vga_control is registered and updated on the same edge as current_gain, computed from the next value of current_gain. vga_control == thermo(current_gain) always holds.
- States: IDLE, STEP, SETTLE, LOCKED.
- IDLE:
  - gain_valid=1: target<=gain_array, next state STEP. gain_valid has priority over done on the same cycle.
  - Otherwise, if done=1 and current_gain==target: next state LOCKED.
  - Otherwise stay in IDLE.
- STEP:
  - current_gain==target: next state IDLE, no change.
  - Otherwise: diff=|target-current_gain| (7-bit unsigned compare, no wrap). current_gain moves toward target by min(diff, MAX_STEP). Counter<=0, next state SETTLE.
  - The value never overshoots and never leaves 0..63.
- SETTLE:
  - Counter increments each cycle.
  - On the edge where counter==SETTLE_CYCLES-1: next state STEP.
  - Step period is therefore SETTLE_CYCLES+1 cycles.
- gain_valid in STEP or SETTLE:
  - target<=gain_array immediately; the counter is not restarted.
  - Stepping continues toward the new target, which may reverse direction.
  - A request equal to current_gain ends the walk at the next STEP.
- LOCKED:
  - locked=1; gain_valid is ignored and target is not updated.
  - done=0: next state IDLE, with locked=0 from that edge.
- busy is registered: high from the edge that captures gain_valid in IDLE until the edge that enters IDLE.
- Every request ends with a settle interval followed by one STEP cycle that confirms convergence before IDLE.
- Simultaneous done=1 and gain_valid=1 in IDLE: the request is captured; the lock is taken later, when back in IDLE with current_gain==target and done still 1.

Test Plan:
1. Reset, then hold idle -> current_gain=32, vga_control=64'h0000_0000_FFFF_FFFF, busy=0, locked=0.
2. Defaults, gain_valid with gain_array=50 at edge E0:
   - current_gain=40 after E1, 48 after E6, 50 after E11
   - IDLE and busy=0 after E16
   - vga_control low 50 bits set
3. From 32, request 0:
   - steps 24, 16, 8, 0, no underflow, vga_control=0
   - then request 63: steps up to 63, vga_control=64'h7FFF_FFFF_FFFF_FFFF
4. Request 50, then during the first SETTLE request 36:
   - current_gain goes 40 then 36; no overshoot
   - counter not restarted: second step lands on edge E6
5. done=1 with converged gain -> locked=1 next edge, busy=0. Then:
   - gain_valid=1 with gain_array=10 while locked -> no change to current_gain or target
   - drop done -> locked=0, IDLE
6. RESET asserted mid-SETTLE -> after that edge current_gain=32, state IDLE, busy=0, vga_control=thermo(32).

Source files
------------

// File: rtl/vga_gain_sequencer.sv
// Walks the applied VGA gain toward the requested AGC target in bounded steps,
// with a settle interval between steps, and locks once the search is done.
module vga_gain_sequencer #(
  parameter int INIT_GAIN     = 32,
  parameter int MAX_STEP      = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [5:0]  gain_array,
  input  logic        gain_valid,
  input  logic        done,
  output logic [63:0] vga_control,
  output logic [5:0]  current_gain,
  output logic        busy,
  output logic        locked
);

  typedef enum logic [1:0] {IDLE, STEP, SETTLE, LOCKED} state_t;

  localparam logic [5:0] INIT_CODE   = 6'(INIT_GAIN);
  localparam logic [6:0] MAX_STEP_W  = 7'(MAX_STEP);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_next;
  logic [5:0]  target, target_next, gain_next;
  logic [3:0]  settle_cnt, settle_cnt_next;
  logic [6:0]  diff, step_size;
  logic [63:0] vga_next;
  logic        busy_next, locked_next;

  function automatic logic [63:0] thermo(input logic [5:0] g);
    logic [63:0] t;
    for (int i = 0; i < 64; i++) begin
      t[i] = (7'(i) < {1'b0, g});
    end
    return t;
  endfunction

  // Distance is taken in 7 bits so the step size can never wrap past 0 or 63
  always_comb begin
    if ({1'b0, target} >= {1'b0, current_gain}) begin
      diff = {1'b0, target} - {1'b0, current_gain};
    end else begin
      diff = {1'b0, current_gain} - {1'b0, target};
    end
    step_size = (diff > MAX_STEP_W) ? MAX_STEP_W : diff;
  end

  always_comb begin
    state_next      = state;
    target_next     = target;
    gain_next       = current_gain;
    settle_cnt_next = settle_cnt;
    case (state)
      IDLE: begin
        if (gain_valid) begin
          target_next = gain_array;
          state_next  = STEP;
        end else if (done && (current_gain == target)) begin
          state_next = LOCKED;
        end
      end
      STEP: begin
        if (gain_valid) begin
          target_next = gain_array;
        end
        if (current_gain == target) begin
          state_next = IDLE;
        end else begin
          if (target > current_gain) begin
            gain_next = current_gain + step_size[5:0];
          end else begin
            gain_next = current_gain - step_size[5:0];
          end
          settle_cnt_next = 4'd0;
          state_next      = SETTLE;
        end
      end
      SETTLE: begin
        if (gain_valid) begin
          target_next = gain_array;
        end
        settle_cnt_next = settle_cnt + 4'd1;
        if (settle_cnt == SETTLE_LAST) begin
          state_next = STEP;
        end
      end
      LOCKED: begin
        if (!done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are derived from next-state values so they register on the same edge
  always_comb begin
    busy_next   = (state_next == STEP) || (state_next == SETTLE);
    locked_next = (state_next == LOCKED);
    vga_next    = thermo(gain_next);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state        <= IDLE;
      current_gain <= INIT_CODE;
      target       <= INIT_CODE;
      settle_cnt   <= 4'd0;
      vga_control  <= thermo(INIT_CODE);
      busy         <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_next;
      current_gain <= gain_next;
      target       <= target_next;
      settle_cnt   <= settle_cnt_next;
      vga_control  <= vga_next;
      busy         <= busy_next;
      locked       <= locked_next;
    end
  end

endmodule

// File: tb/tb_vga_gain_sequencer.sv
// Scoreboard bench for vga_gain_sequencer: a cycle-level behavioural model
// pushes expected outputs each edge and a monitor compares them on negedge.
module tb_vga_gain_sequencer;

  localparam int INIT_GAIN     = 32;
  localparam int MAX_STEP      = 8;
  localparam int SETTLE_CYCLES = 4;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [5:0]  gain_array = 6'd0;
  logic        gain_valid = 1'b0;
  logic        done = 1'b0;
  logic [63:0] vga_control;
  logic [5:0]  current_gain;
  logic        busy;
  logic        locked;

  vga_gain_sequencer #(
    .INIT_GAIN(INIT_GAIN),
    .MAX_STEP(MAX_STEP),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk),
    .RESET(RESET),
    .gain_array(gain_array),
    .gain_valid(gain_valid),
    .done(done),
    .vga_control(vga_control),
    .current_gain(current_gain),
    .busy(busy),
    .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] vga;
    logic [5:0]  gain;
    logic        busy;
    logic        locked;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state: a walk in progress waits a number of edges before moving
  int mGain, mTarget, mWait;
  bit mWalking, mLocked;

  function automatic logic [63:0] thermoRef(input int g);
    logic [64:0] w;
    w = (65'd1 << g) - 65'd1;
    return w[63:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit gv, input logic [5:0] ga, input bit dn);
    RESET      = r;
    gain_valid = gv;
    gain_array = ga;
    done       = dn;
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    int step;
    if (RESET) begin
      mGain = INIT_GAIN; mTarget = INIT_GAIN; mWalking = 0; mLocked = 0; mWait = 0;
    end else if (mLocked) begin
      if (!done) mLocked = 0;
    end else if (!mWalking) begin
      if (gain_valid) begin
        mTarget = gain_array; mWalking = 1; mWait = 0;
      end else if (done && mGain == mTarget) begin
        mLocked = 1;
      end
    end else begin
      if (mWait == 0) begin
        if (mGain == mTarget) begin
          mWalking = 0;
        end else begin
          step = (mTarget > mGain) ? mTarget - mGain : mGain - mTarget;
          if (step > MAX_STEP) step = MAX_STEP;
          mGain = (mTarget > mGain) ? mGain + step : mGain - step;
          mWait = SETTLE_CYCLES;
        end
      end else begin
        mWait--;
      end
      if (gain_valid) mTarget = gain_array;
    end
    e.vga = thermoRef(mGain);
    e.gain = 6'(mGain);
    e.busy = mWalking;
    e.locked = mLocked;
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("current_gain", 64'(current_gain), 64'(e.gain));
      checkOutput("vga_control", vga_control, e.vga);
      checkOutput("busy", 64'(busy), 64'(e.busy));
      checkOutput("locked", 64'(locked), 64'(e.locked));
    end
  end

  initial begin
    @(negedge clk);
    applyStimulus(1, 0, 6'd0, 0);
    applyStimulus(1, 0, 6'd0, 0);
    repeat (3) applyStimulus(0, 0, 6'd0, 0);
    checkOutput("reset_gain", 64'(current_gain), 64'd32);
    checkOutput("reset_vga", vga_control, 64'h0000_0000_FFFF_FFFF);
    checkOutput("reset_busy", 64'(busy), 64'd0);

    applyStimulus(0, 1, 6'd50, 0);
    checkOutput("step_busy", 64'(busy), 64'd1);
    applyStimulus(0, 0, 6'd0, 0);
    checkOutput("first_step", 64'(current_gain), 64'd40);
    repeat (10) applyStimulus(0, 0, 6'd0, 0);
    checkOutput("third_step", 64'(current_gain), 64'd50);
    repeat (5) applyStimulus(0, 0, 6'd0, 0);
    checkOutput("walk50_busy", 64'(busy), 64'd0);
    checkOutput("walk50_vga", vga_control, thermoRef(50));

    applyStimulus(1, 0, 6'd0, 0);
    applyStimulus(0, 1, 6'd0, 0);
    repeat (22) applyStimulus(0, 0, 6'd0, 0);
    checkOutput("floor_gain", 64'(current_gain), 64'd0);
    checkOutput("floor_vga", vga_control, 64'd0);
    applyStimulus(0, 1, 6'd63, 0);
    repeat (42) applyStimulus(0, 0, 6'd0, 0);
    checkOutput("ceil_gain", 64'(current_gain), 64'd63);
    checkOutput("ceil_vga", vga_control, 64'h7FFF_FFFF_FFFF_FFFF);

    applyStimulus(1, 0, 6'd0, 0);
    applyStimulus(0, 1, 6'd50, 0);
    applyStimulus(0, 0, 6'd0, 0);
    applyStimulus(0, 1, 6'd36, 0);
    repeat (3) applyStimulus(0, 0, 6'd0, 0);
    checkOutput("redirect_pre", 64'(current_gain), 64'd40);
    applyStimulus(0, 0, 6'd0, 0);
    checkOutput("redirect_step", 64'(current_gain), 64'd36);
    repeat (6) applyStimulus(0, 0, 6'd0, 0);

    applyStimulus(0, 0, 6'd0, 1);
    checkOutput("lock_on", 64'(locked), 64'd1);
    applyStimulus(0, 1, 6'd10, 1);
    repeat (3) applyStimulus(0, 0, 6'd0, 1);
    checkOutput("lock_hold", 64'(current_gain), 64'd36);
    applyStimulus(0, 0, 6'd0, 0);
    checkOutput("lock_off", 64'(locked), 64'd0);
    applyStimulus(0, 0, 6'd0, 0);
    checkOutput("lock_ignored_req", 64'(busy), 64'd0);

    applyStimulus(0, 1, 6'd5, 0);
    repeat (3) applyStimulus(0, 0, 6'd0, 0);
    applyStimulus(1, 0, 6'd0, 0);
    checkOutput("midreset_gain", 64'(current_gain), 64'd32);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_vga", vga_control, thermoRef(32));

    // Random traffic with done held as a slowly changing level
    begin
      bit dn = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) dn = ~dn;
        applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
                      6'($urandom_range(0, 63)), dn);
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
